// File: rtl/mod_inv_div_pkg.sv
// Shared definitions for the modular inverse / division engine.
//   N_DEF   : default operand width in bits
//   W_DEF   : default data bus width in bits
//   state_e : controller state encoding
package mod_inv_div_pkg;

    localparam int unsigned N_DEF = 256;
    localparam int unsigned W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mod_half.sv
// Modular halving: returns x/2 mod p for odd p and x < p.
//   x_i      : value to halve (N bits)
//   p_i      : odd modulus (N bits)
//   half_c_o : combinational result, x>>1 when x is even, else (x+p)>>1
module mod_half #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] p_i,
    output logic [N-1:0] half_c_o
);

    // Odd x: x+p is even, and the carry out of the N-bit add becomes the top bit.
    always_comb begin
        if (x_i[0]) begin
            half_c_o = N'(({1'b0, x_i} + {1'b0, p_i}) >> 1);
        end else begin
            half_c_o = x_i >> 1;
        end
    end

endmodule

// File: rtl/mod_inv_div_n.sv
// Binary extended-Euclid engine computing a^-1 mod p (mode=1) or b/a mod p
// (mode=0), one reduction step per clock.
//   clk, rst               : clock, asynchronous active-low reset
//   datain, load_a/b/p     : word-serial operand loading, LS word first
//   mode, start            : operation select and single-cycle request
//   rd                     : result readout strobe (DONE only)
//   dout, dout_vld         : registered result word and its valid
//   busy, rdy, flag        : INIT/RUN indicator, completion pulse, error
module mod_inv_div_n
    import mod_inv_div_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] datain,
    input  logic         load_a,
    input  logic         load_b,
    input  logic         load_p,
    input  logic         mode,
    input  logic         start,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         dout_vld,
    output logic         busy,
    output logic         rdy,
    output logic         flag
);

    localparam int unsigned NW = N / W;
    localparam int unsigned CW = $clog2(NW + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, p_q, p_d;
    logic [N-1:0]  u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
    logic [N-1:0]  res_q, res_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          flag_q, flag_d;

    logic          u_ge_v;
    logic [N-1:0]  uv_diff;
    logic [N-1:0]  sub_x, sub_y, sub_res;
    logic [N:0]    sub_diff;
    logic [N-1:0]  half_in, half_out;

    // Shared datapath: only one of the x1/x2 updates happens per step.
    always_comb begin
        u_ge_v   = (u_q >= v_q);
        uv_diff  = u_ge_v ? (u_q - v_q) : (v_q - u_q);
        sub_x    = u_ge_v ? x1_q : x2_q;
        sub_y    = u_ge_v ? x2_q : x1_q;
        sub_diff = {1'b0, sub_x} - {1'b0, sub_y};
        sub_res  = sub_diff[N] ? (sub_diff[N-1:0] + p_q) : sub_diff[N-1:0];
        half_in  = u_q[0] ? x2_q : x1_q;
    end

    mod_half #(.N(N)) u_half (
        .x_i      (half_in),
        .p_i      (p_q),
        .half_c_o (half_out)
    );

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        u_d        = u_q;
        v_d        = v_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        res_d      = res_q;
        mode_d     = mode_q;
        rd_cnt_d   = rd_cnt_q;
        dout_d     = '0;
        dout_vld_d = 1'b0;
        rdy_d      = 1'b0;
        flag_d     = flag_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_a) a_d = {datain, a_q[N-1:W]};
                if (load_b) b_d = {datain, b_q[N-1:W]};
                if (load_p) p_d = {datain, p_q[N-1:W]};
                if (state_q == ST_DONE && rd && rd_cnt_q < CW'(NW)) begin
                    dout_d     = res_q[W-1:0];
                    dout_vld_d = 1'b1;
                    res_d      = res_q >> W;
                    rd_cnt_d   = rd_cnt_q + CW'(1);
                end
                if (start) begin
                    state_d  = ST_INIT;
                    mode_d   = mode;
                    flag_d   = 1'b0;
                    rd_cnt_d = '0;
                end
            end
            ST_INIT: begin
                u_d   = a_q;
                v_d   = p_q;
                x1_d  = mode_q ? N'(1) : b_q;
                x2_d  = '0;
                res_d = '0;
                if (a_q == '0 || !p_q[0] || p_q < N'(3)) begin
                    flag_d  = 1'b1;
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (u_q == N'(1)) begin
                    res_d   = x1_q;
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else if (v_q == N'(1)) begin
                    res_d   = x2_q;
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else if (u_q == '0 || v_q == '0) begin
                    flag_d  = 1'b1;
                    res_d   = '0;
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_out;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_out;
                end else if (u_ge_v) begin
                    u_d  = uv_diff;
                    x1_d = sub_res;
                end else begin
                    v_d  = uv_diff;
                    x2_d = sub_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_INIT) || (state_d == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            res_q      <= '0;
            mode_q     <= 1'b0;
            rd_cnt_q   <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            u_q        <= u_d;
            v_q        <= v_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            res_q      <= res_d;
            mode_q     <= mode_d;
            rd_cnt_q   <= rd_cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
            flag_q     <= flag_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;
    assign rdy      = rdy_q;
    assign flag     = flag_q;

endmodule

// File: tb/tb_mod_inv_div_n.sv
// Bench for mod_inv_div_n: a 16/8 instance for small directed and random
// cases, a 256/16 instance for SM2-prime cases. Expected words and flags are
// queued at issue time and consumed by a monitor when the DUT presents them.
module tb_mod_inv_div_n;
    import mod_inv_div_pkg::*;

    localparam int unsigned SN = 16;
    localparam int unsigned SW = 8;
    localparam int unsigned LN = 256;
    localparam int unsigned LW = 16;
    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [SW-1:0] s_din = '0;
    logic s_la = 0, s_lb = 0, s_lp = 0, s_mode = 0, s_start = 0, s_rd = 0;
    logic [SW-1:0] s_dout;
    logic s_vld, s_busy, s_rdy, s_flag;

    logic [LW-1:0] l_din = '0;
    logic l_la = 0, l_lb = 0, l_lp = 0, l_mode = 0, l_start = 0, l_rd = 0;
    logic [LW-1:0] l_dout;
    logic l_vld, l_busy, l_rdy, l_flag;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] s_wq[$];
    logic [255:0] l_wq[$];
    logic s_fq[$];
    logic l_fq[$];

    always #5 clk = ~clk;

    mod_inv_div_n #(.N(SN), .W(SW)) u_small (
        .clk(clk), .rst(rst), .datain(s_din), .load_a(s_la), .load_b(s_lb),
        .load_p(s_lp), .mode(s_mode), .start(s_start), .rd(s_rd),
        .dout(s_dout), .dout_vld(s_vld), .busy(s_busy), .rdy(s_rdy), .flag(s_flag)
    );

    mod_inv_div_n #(.N(LN), .W(LW)) u_large (
        .clk(clk), .rst(rst), .datain(l_din), .load_a(l_la), .load_b(l_lb),
        .load_p(l_lp), .mode(l_mode), .start(l_start), .rd(l_rd),
        .dout(l_dout), .dout_vld(l_vld), .busy(l_busy), .rdy(l_rdy), .flag(l_flag)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (number theory, not the RTL step list)
    function automatic logic [255:0] mulmod(input logic [255:0] x, y, m);
        logic [511:0] pr;
        pr = {256'd0, x} * {256'd0, y};
        pr = pr % {256'd0, m};
        return pr[255:0];
    endfunction

    function automatic logic [255:0] powmod(input logic [255:0] base, e, m);
        logic [255:0] r, bb;
        r  = 256'd1;
        bb = base % m;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, bb, m);
            bb = mulmod(bb, bb, m);
        end
        return r;
    endfunction

    function automatic logic [255:0] gcd(input logic [255:0] x, y);
        logic [255:0] t;
        for (int i = 0; i < 2000 && y != 0; i++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Valid only for prime p on the coprime path (Fermat inverse).
    task automatic model(input logic md, input logic [255:0] a, b, p,
                         output logic fl, output logic [255:0] res);
        if (a == 0 || !p[0] || p < 3 || gcd(a, p) != 1) begin
            fl  = 1'b1;
            res = '0;
        end else begin
            fl  = 1'b0;
            res = mulmod(md ? 256'd1 : b, powmod(a, p - 2, p), p);
        end
    endtask

    // ---------------- monitor: consumes expected words and flags
    always @(negedge clk) begin
        logic [255:0] ew;
        logic ef;
        if (s_vld) begin
            if (s_wq.size() == 0) chk("s_unexpected_word", {1'b1, s_dout}, '0);
            else begin ew = s_wq.pop_front(); chk("s_dout", 256'(s_dout), ew); end
        end
        if (l_vld) begin
            if (l_wq.size() == 0) chk("l_unexpected_word", {1'b1, l_dout}, '0);
            else begin ew = l_wq.pop_front(); chk("l_dout", 256'(l_dout), ew); end
        end
        if (s_rdy) begin
            if (s_fq.size() == 0) chk("s_unexpected_rdy", 256'(1), '0);
            else begin ef = s_fq.pop_front(); chk("s_flag", 256'(s_flag), 256'(ef)); end
        end
        if (l_rdy) begin
            if (l_fq.size() == 0) chk("l_unexpected_rdy", 256'(1), '0);
            else begin ef = l_fq.pop_front(); chk("l_flag", 256'(l_flag), 256'(ef)); end
        end
    end

    // ---------------- stimulus helpers
    task automatic set_in(input int sel, input logic [15:0] d, input logic la, lb, lp,
                          input logic st, rdv, md);
        if (sel == 0) begin
            s_din = d[7:0]; s_la = la; s_lb = lb; s_lp = lp;
            s_start = st; s_rd = rdv; s_mode = md;
        end else begin
            l_din = d; l_la = la; l_lb = lb; l_lp = lp;
            l_start = st; l_rd = rdv; l_mode = md;
        end
    endtask

    function automatic logic o_rdy(input int sel);
        return (sel != 0) ? l_rdy : s_rdy;
    endfunction

    function automatic logic [16:0] o_rd_out(input int sel);
        return (sel != 0) ? {l_vld, l_dout} : {s_vld, 8'd0, s_dout};
    endfunction

    task automatic load(input int sel, input logic md, input logic [255:0] a, b, p);
        int ww = (sel != 0) ? LW : SW;
        int nw = ((sel != 0) ? LN : SN) / ww;
        logic [255:0] v;
        for (int r = 0; r < 3; r++) begin
            v = (r == 0) ? a : (r == 1) ? b : p;
            for (int i = 0; i < nw; i++) begin
                @(negedge clk);
                set_in(sel, 16'(v >> (ww * i)), r == 0, r == 1, r == 2, 1'b0, 1'b0, md);
            end
        end
        @(negedge clk);
        set_in(sel, '0, 0, 0, 0, 0, 0, md);
    endtask

    task automatic run_op(input int sel, input logic md, input logic [255:0] a, b, p,
                          input int exact_lat, input bit reads, input bit extra,
                          input bit poke, input int abort_at);
        int nn = (sel != 0) ? LN : SN;
        int ww = (sel != 0) ? LW : SW;
        int nw = nn / ww;
        logic fl;
        logic [255:0] res, mask;
        int lat;
        bit seen;
        model(md, a, b, p, fl, res);
        load(sel, md, a, b, p);
        mask = (256'd1 << ww) - 256'd1;
        if (abort_at == 0) begin
            if (sel != 0) l_fq.push_back(fl); else s_fq.push_back(fl);
            if (reads)
                for (int i = 0; i < nw; i++) begin
                    if (sel != 0) l_wq.push_back((res >> (ww * i)) & mask);
                    else          s_wq.push_back((res >> (ww * i)) & mask);
                end
        end
        @(negedge clk);
        set_in(sel, '0, 0, 0, 0, 1'b1, 0, md);
        seen = 0;
        lat  = 0;
        for (int c = 1; c <= 4 * nn + 20 && !seen; c++) begin
            @(negedge clk);
            lat = c;
            if (poke && c == 3) set_in(sel, 16'($urandom), 1, 1, 1, 1'b1, 0, ~md);
            else                set_in(sel, '0, 0, 0, 0, 0, 0, md);
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b0;
                #2;
                chk("abort_outputs", {l_dout, l_vld, l_busy, l_rdy, l_flag}, '0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            if (o_rdy(sel)) seen = 1;
        end
        if (!seen) begin
            chk("rdy_timeout", 256'(lat), 256'(4 * nn + 4));
            s_wq.delete(); l_wq.delete(); s_fq.delete(); l_fq.delete();
            return;
        end
        if (exact_lat >= 0) chk("latency", 256'(lat), 256'(exact_lat));
        else begin
            n_vec++;
            if (lat > 4 * nn + 4) begin
                n_err++;
                $display("FAIL latency_bound: got %0d cycles, limit %0d", lat, 4 * nn + 4);
            end
        end
        if (reads) begin
            for (int i = 0; i < nw; i++) begin
                @(negedge clk);
                set_in(sel, '0, 0, 0, 0, 0, 1'b1, md);
            end
            @(negedge clk);
            set_in(sel, '0, 0, 0, 0, 0, 0, md);
        end
        if (extra) begin
            @(negedge clk);
            set_in(sel, '0, 0, 0, 0, 0, 1'b1, md);
            @(negedge clk);
            set_in(sel, '0, 0, 0, 0, 0, 0, md);
            chk("extra_read", 256'(o_rd_out(sel)), '0);
        end
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        int unsigned plist[5] = '{11, 13, 251, 32749, 65521};
        logic [255:0] a, b, p;
        #1 rst = 1'b0;
        #6;
        chk("reset_small", {s_dout, s_vld, s_busy, s_rdy, s_flag}, '0);
        chk("reset_large", {l_dout, l_vld, l_busy, l_rdy, l_flag}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Small directed cases.
        run_op(0, 1'b1, 256'd5, 256'd0, 256'd11, -1, 1, 1, 0, 0);
        run_op(0, 1'b0, 256'd5, 256'd3, 256'd11, -1, 1, 0, 0, 0);
        run_op(0, 1'b1, 256'd0, 256'd0, 256'd11,  2, 0, 0, 0, 0);
        run_op(0, 1'b1, 256'd3, 256'd0, 256'd10, -1, 0, 0, 0, 0);
        run_op(0, 1'b1, 256'd7, 256'd0, 256'd21, -1, 1, 0, 0, 0);
        run_op(0, 1'b0, 256'd5, 256'd3, 256'd11, -1, 1, 0, 1, 0);

        // Small random cases over a few primes.
        for (int k = 0; k < 12; k++) begin
            p = 256'(plist[$urandom_range(4, 0)]);
            a = 256'($urandom_range(int'(p) - 1, 1));
            b = 256'($urandom_range(int'(p) - 1, 0));
            run_op(0, 1'($urandom), a, b, p, -1, 1, (k == 0), (k == 1), 0);
        end

        // Large random cases on the SM2 prime, both modes.
        for (int k = 0; k < 4; k++) begin
            a = rand256() % SM2_P;
            if (a == 0) a = 256'd1;
            b = rand256() % SM2_P;
            run_op(1, 1'(k % 2), a, b, SM2_P, -1, 1, 0, (k == 2), 0);
        end

        // Reset mid-RUN on the large instance, then a clean op afterwards.
        run_op(1, 1'b1, rand256() % SM2_P | 256'd1, 256'd0, SM2_P, -1, 0, 0, 0, 20);
        run_op(0, 1'b1, 256'd5, 256'd0, 256'd11, -1, 1, 0, 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 256'(s_wq.size() + l_wq.size() + s_fq.size() + l_fq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
